// File: rtl/scan_lut_reader_pkg.sv
// Shared types and mode constants for the scan lookup reader.
package scan_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESP
  } state_e;

  localparam int SCAN_LINEAR = 0;
  localparam int SCAN_DIRECT = 1;

endpackage

// File: rtl/scan_lut_reader_if.sv
// Table write port, lookup request/response handshake and status for scan_lut_reader.
interface scan_lut_reader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 6
);
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [DATA_W-1:0] RSP_DATA;
  logic              RSP_HIT;
  logic              CLR;
  logic              BUSY;
  logic [ADDR_W-1:0] SCAN_ADDR;

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, REQ_VALID, REQ_ADDR, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_HIT, CLR, BUSY, SCAN_ADDR
  );

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, REQ_VALID, REQ_ADDR, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_HIT, CLR, BUSY, SCAN_ADDR
  );
endinterface

// File: rtl/scan_lut_reader_scan_counter.sv
// Scan address counter: synchronous clear, count enable and last-entry flag.
module scan_counter #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_term
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == LAST);
endmodule

// File: rtl/scan_lut_reader.sv
// Lookup reader: scans (or directly indexes) a run-time writable table and returns
// data, hit flag and a one-cycle active-low CLR pulse on hits.
module scan_lut_reader
  import scan_lut_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 6,
  parameter int                DEPTH     = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] DEF_DATA  = {DATA_W{1'b1}},
  parameter int                SCAN_MODE = SCAN_LINEAR
) (
  input logic CLK,
  input logic RST,
  scan_lut_reader_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_table [DEPTH];
  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_hit;
  logic              r_clr;
  logic              r_busy;

  logic              w_accept;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_count;
  logic              w_term;
  logic              w_match;
  logic              w_in_range;
  logic              w_cnt_en;
  logic              w_done;
  logic              w_hit_now;
  logic [ADDR_W-1:0] w_rd_idx;

  assign bus.REQ_READY = (r_state == ST_IDLE) && !RST;
  assign w_accept      = bus.REQ_VALID && bus.REQ_READY;
  assign w_wr_ok       = bus.WR_EN && ({1'b0, bus.WR_ADDR} < DEPTH_X);
  assign w_match       = (w_count == r_addr);
  assign w_in_range    = ({1'b0, r_addr} < DEPTH_X);

  // Direct mode resolves in the single SCAN cycle; linear mode stops on match or last entry.
  assign w_done    = (SCAN_MODE == SCAN_DIRECT) ? 1'b1 : (w_match || w_term);
  assign w_hit_now = (SCAN_MODE == SCAN_DIRECT) ? w_in_range : w_match;
  assign w_rd_idx  = (SCAN_MODE == SCAN_DIRECT) ? r_addr : w_count;
  assign w_cnt_en  = (r_state == ST_SCAN) && (SCAN_MODE == SCAN_LINEAR) && !w_done;

  scan_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_scan_counter (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (w_accept),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_term  (w_term)
  );

  // A write and a read of the same entry on one edge returns the old contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= DATA_W'(i);
      end
    end else if (w_wr_ok) begin
      r_table[bus.WR_ADDR] <= bus.WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= DEF_DATA;
      r_rsp_hit   <= 1'b0;
      r_clr       <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.REQ_ADDR;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
            if (w_hit_now) begin
              r_rsp_data <= r_table[w_rd_idx];
              r_rsp_hit  <= 1'b1;
              r_clr      <= 1'b0;
            end else begin
              r_rsp_data <= DEF_DATA;
              r_rsp_hit  <= 1'b0;
              r_clr      <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          r_clr <= 1'b1;
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_DATA  = r_rsp_data;
  assign bus.RSP_HIT   = r_rsp_hit;
  assign bus.CLR       = r_clr;
  assign bus.BUSY      = r_busy;
  assign bus.SCAN_ADDR = w_count;
endmodule
